aux_replay: RTL and testbench

Receive-side audio/aux replay scheduler. Pops 25-bit aux entries {pos[15:0], aux[8:0]} from the receive aux FIFO (written by `gmii2fifo24`) and re-emits each aux word on the exact blanking-relative pixel position at which the transmit side captured it. The result is a regenerated ADE strobe plus 9-bit aux data, aligned with the locally generated video timing. It sits between `afifo25` (recv) and the TMDS encoder in the pixel-clock domain. It is the counterpart of the transmit-side capture that packs `{posbuf, ax2, ax1, ax0[2]}`.

---
 rtl/hdmi_ts_pkg.sv | 18 +
 rtl/aux_replay_if.sv | 9 +
 rtl/blank_pos_counter.sv | 36 +++
 rtl/aux_replay.sv | 142 ++++++++++++++
 tb/tb_aux_replay.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/hdmi_ts_pkg.sv
// rtl/hdmi_ts_pkg.sv - shared aux entry layout, replay state encoding and burst length
package hdmi_ts_pkg;

    localparam int AUX_ENTRY_W  = 25;
    localparam int AUX_POS_LSB  = 9;
    localparam int AUX_DATA_LSB = 0;
    localparam int ADE_LEN      = 32;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_ARMED = 2'd2;

    typedef struct packed {
        logic [15:0] pos;
        logic [8:0]  aux;
    } aux_entry_t;

endpackage

// File: rtl/aux_replay_if.sv
// rtl/aux_replay_if.sv - receive aux FIFO read port (non-FWFT, Q valid one cycle after pop)
interface aux_replay_if #(parameter int W = hdmi_ts_pkg::AUX_ENTRY_W);
    logic [W-1:0] ax_dout;
    logic         ax_empty;
    logic         ax_rd_en;

    modport master (input ax_dout, input ax_empty, output ax_rd_en);
    modport slave  (output ax_dout, output ax_empty, input ax_rd_en);
endinterface

// File: rtl/blank_pos_counter.sv
// rtl/blank_pos_counter.sv - blanking-relative pixel position, cleared by vde, saturating
module blank_pos_counter #(
    parameter int POS_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vde_i,
    output logic [POS_W-1:0] pos_o,
    output logic [POS_W-1:0] pos_next_o
);

    logic [POS_W-1:0] pos_q;
    logic [POS_W-1:0] pos_d;

    always_comb begin
        if (vde_i) begin
            pos_d = '0;
        end else if (&pos_q) begin
            pos_d = pos_q;
        end else begin
            pos_d = pos_q + POS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos_o      = pos_q;
    assign pos_next_o = pos_d;

endmodule

// File: rtl/aux_replay.sv
// rtl/aux_replay.sv - replays captured aux words at their original blanking position
module aux_replay #(
    parameter int POS_W   = 16,
    parameter int AUX_W   = 9,
    parameter int ADE_LEN = hdmi_ts_pkg::ADE_LEN
) (
    input  logic             fifo_clk,
    input  logic             sys_rst,
    input  logic             vde,
    aux_replay_if.master     ax,
    output logic             ade,
    output logic [AUX_W-1:0] aux_out,
    output logic [3:0]       ade_num,
    output logic [7:0]       drop_cnt
);
    import hdmi_ts_pkg::*;

    localparam int BEAT_W = (ADE_LEN > 1) ? $clog2(ADE_LEN) : 1;

    logic [POS_W-1:0]  pos;
    logic [POS_W-1:0]  pos_next;
    logic [POS_W-1:0]  hp;
    logic [AUX_W-1:0]  hd;

    logic [1:0]        state_q, state_d;
    logic              ade_q, ade_d;
    logic [AUX_W-1:0]  aux_q, aux_d;
    logic [7:0]        drop_q, drop_d;
    logic              rd_en;

    logic              vde_q;
    logic [BEAT_W-1:0] beat_q;
    logic [3:0]        burst_q;
    logic [3:0]        num_q;

    blank_pos_counter #(.POS_W(POS_W)) u_pos (
        .clk        (fifo_clk),
        .rst        (sys_rst),
        .vde_i      (vde),
        .pos_o      (pos),
        .pos_next_o (pos_next)
    );

    assign hp = ax.ax_dout[AUX_W +: POS_W];
    assign hd = ax.ax_dout[AUX_DATA_LSB +: AUX_W];

    // Decisions look one cycle ahead (pos_next) so the registered ade lands on pos == hp.
    always_comb begin
        state_d = state_q;
        ade_d   = 1'b0;
        aux_d   = aux_q;
        drop_d  = drop_q;
        rd_en   = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (vde) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!ax.ax_empty) begin
                    rd_en   = 1'b1;
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (hp == '0 || (!vde && hp < pos_next)) begin
                    rd_en = !ax.ax_empty;
                    if (ax.ax_empty) begin
                        state_d = ST_FETCH;
                    end
                    if (drop_q != 8'hFF) begin
                        drop_d = drop_q + 8'd1;
                    end
                end else if (hp == pos_next) begin
                    rd_en = !ax.ax_empty;
                    ade_d = 1'b1;
                    aux_d = hd;
                    if (ax.ax_empty) begin
                        state_d = ST_FETCH;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge fifo_clk) begin
        if (sys_rst) begin
            state_q <= ST_INIT;
            ade_q   <= 1'b0;
            aux_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            ade_q   <= ade_d;
            aux_q   <= aux_d;
            drop_q  <= drop_d;
        end
    end

    // Burst tally for the blanking interval just ended is published on the vde rising edge.
    always_ff @(posedge fifo_clk) begin
        if (sys_rst) begin
            vde_q   <= 1'b0;
            beat_q  <= '0;
            burst_q <= '0;
            num_q   <= '0;
        end else begin
            vde_q <= vde;
            if (vde && !vde_q) begin
                num_q   <= burst_q;
                burst_q <= '0;
                beat_q  <= '0;
            end else if (ade_q) begin
                if (beat_q == BEAT_W'(ADE_LEN - 1)) begin
                    beat_q <= '0;
                    if (burst_q != 4'hF) begin
                        burst_q <= burst_q + 4'd1;
                    end
                end else begin
                    beat_q <= beat_q + BEAT_W'(1);
                end
            end
        end
    end

    assign ax.ax_rd_en = rd_en;
    assign ade         = ade_q;
    assign aux_out     = aux_q;
    assign ade_num     = num_q;
    assign drop_cnt    = drop_q;

    a_no_empty_pop: assert property (@(posedge fifo_clk) disable iff (sys_rst)
        !(ax.ax_rd_en && ax.ax_empty));

    a_no_fire_at_zero: assert property (@(posedge fifo_clk) disable iff (sys_rst)
        ade |-> (pos != '0));

endmodule

// File: tb/tb_aux_replay.sv
// tb/tb_aux_replay.sv - directed bench for aux_replay with a position-schedule model
module tb_aux_replay;

    logic       clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       vde = 1'b0;
    logic       ade;
    logic [8:0] aux_out;
    logic [3:0] ade_num;
    logic [7:0] drop_cnt;

    aux_replay_if #(.W(25)) ax ();

    aux_replay dut (
        .fifo_clk (clk),
        .sys_rst  (sys_rst),
        .vde      (vde),
        .ax       (ax),
        .ade      (ade),
        .aux_out  (aux_out),
        .ade_num  (ade_num),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // Non-FWFT FIFO: stimulus owns mem/wptr, this process owns rptr/q_reg.
    logic [24:0] mem [0:1023];
    int          wptr = 0;
    int          rptr = 0;
    logic [24:0] q_reg = '0;

    assign ax.ax_dout  = q_reg;
    assign ax.ax_empty = (rptr == wptr);

    always @(posedge clk) begin
        if (sys_rst) begin
            rptr <= wptr;
        end else if (ax.ax_rd_en && rptr != wptr) begin
            q_reg <= mem[rptr[9:0]];
            rptr  <= rptr + 1;
        end
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Expected per-interval literals: ade beats, published ade_num, drop_cnt at each vde rise.
    int nade_tab [8] = '{0, 1, 32, 64, 1, 32, 0, 1};
    int num_tab  [8] = '{0, 0, 1,  2,  0, 1,  0, 0};
    int drop_tab [8] = '{0, 0, 0,  0,  1, 1,  0, 0};

    int          pos_m = 0;
    int          mptr = 0;
    int          beats = 0;
    int          n_ade = 0;
    int          drops_m = 0;
    int          exp_num = 0;
    int          k = 0;
    int          p;
    bit          started = 0;
    bit          vde_prev = 0;
    bit          exp_ade = 0;
    bit          rise;
    bit          tmo = 0;
    logic [8:0]  exp_aux = '0;
    logic [24:0] e;

    always begin
        @(posedge clk);
        #2;
        if (sys_rst) begin
            pos_m = 0; started = 0; vde_prev = 0; beats = 0; exp_num = 0;
            drops_m = 0; n_ade = 0; mptr = wptr; exp_ade = 0;
            chk("rst_ade", int'(ade), 0);
            chk("rst_ade_num", int'(ade_num), 0);
            chk("rst_drop_cnt", int'(drop_cnt), 0);
            chk("rst_rd_en", int'(ax.ax_rd_en), 0);
        end else begin
            rise  = vde && !vde_prev;
            pos_m = vde ? 0 : ((pos_m == 65535) ? pos_m : pos_m + 1);
            if (rise) begin
                exp_num = (beats / 32 > 15) ? 15 : beats / 32;
                if (k < 8) begin
                    chk("interval_beats", n_ade, nade_tab[k]);
                    chk("interval_ade_num", int'(ade_num), num_tab[k]);
                    chk("interval_drop_cnt", int'(drop_cnt), drop_tab[k]);
                    chk("model_drop_cnt", int'(drop_cnt), drops_m);
                end
                k++;
                beats = 0;
                n_ade = 0;
            end
            if (vde) started = 1;
            vde_prev = vde;
            exp_ade  = 0;
            if (started) begin
                while (mptr < wptr) begin
                    e = mem[mptr[9:0]];
                    p = int'(e[24:9]);
                    if (p == 0 || p < pos_m) begin
                        mptr++;
                        if (drops_m < 255) drops_m++;
                    end else if (p == pos_m) begin
                        exp_ade = 1;
                        exp_aux = e[8:0];
                        mptr++;
                        break;
                    end else begin
                        break;
                    end
                end
            end
            beats += int'(exp_ade);
            n_ade += int'(exp_ade);
            chk("ade", int'(ade), int'(exp_ade));
            if (exp_ade) chk("aux_out", int'(aux_out), int'(exp_aux));
            chk("ade_num", int'(ade_num), exp_num);
            chk("pop_while_empty", int'(ax.ax_rd_en && ax.ax_empty), 0);
            if (!started) chk("init_no_pop", int'(ax.ax_rd_en), 0);
            chk("wait_bound", int'(tmo), 0);
        end
    end

    task automatic push(input int pp, input int a);
        mem[wptr[9:0]] = {pp[15:0], a[8:0]};
        wptr++;
    endtask

    task automatic vde_pulse(input int n);
        vde = 1'b1;
        repeat (n) @(negedge clk);
        vde = 1'b0;
    endtask

    task automatic wait_pos(input int target);
        int g = 0;
        while (pos_m != target && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (pos_m != target) tmo = 1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        sys_rst = 1'b0;

        push(5, 'h055);
        repeat (20) @(negedge clk);
        vde_pulse(8);
        repeat (20) @(negedge clk);

        for (int i = 0; i < 32; i++) push(100 + i, i);
        vde_pulse(8);
        repeat (150) @(negedge clk);

        for (int i = 0; i < 32; i++) push(100 + i, 'h100 + i);
        for (int i = 0; i < 32; i++) push(300 + i, 'h180 + i);
        vde_pulse(8);
        repeat (350) @(negedge clk);

        vde_pulse(8);
        wait_pos(50);
        push(3, 'h033);
        push(60, 'h1AA);
        repeat (60) @(negedge clk);

        for (int i = 0; i < 10; i++) push(100 + i, 'h040 + i);
        vde_pulse(8);
        wait_pos(108);
        for (int i = 10; i < 32; i++) push(100 + i, 'h040 + i);
        repeat (60) @(negedge clk);

        for (int i = 0; i < 32; i++) push(100 + i, 'h0C0 + i);
        vde_pulse(8);
        begin
            int g = 0;
            while (n_ade < 5 && g < 2000) begin
                @(negedge clk);
                g++;
            end
            if (n_ade < 5) tmo = 1;
        end
        sys_rst = 1'b1;
        repeat (2) @(negedge clk);
        sys_rst = 1'b0;

        push(20, 'h0AB);
        repeat (10) @(negedge clk);
        vde_pulse(8);
        repeat (40) @(negedge clk);
        vde = 1'b1;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
